// File: rtl/accel_sched_pkg.sv
// Shared definitions for the layer scheduler: register map, CTRL bits,
// FSM state encoding and payload/status layouts.
package accel_sched_pkg;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned WD_W   = 24;

    localparam logic [ADDR_W-1:0] ADDR_IN_BASE   = 6'd21;
    localparam logic [ADDR_W-1:0] ADDR_WT_BASE   = 6'd22;
    localparam logic [ADDR_W-1:0] ADDR_OUT_BASE  = 6'd23;
    localparam logic [ADDR_W-1:0] ADDR_LAYER_CNT = 6'd24;
    localparam logic [ADDR_W-1:0] ADDR_FM_STRIDE = 6'd25;
    localparam logic [ADDR_W-1:0] ADDR_WT_STRIDE = 6'd26;
    localparam logic [ADDR_W-1:0] ADDR_CTRL      = 6'd27;

    localparam int unsigned CTRL_START   = 0;
    localparam int unsigned CTRL_ABORT   = 1;
    localparam int unsigned CTRL_IRQ_CLR = 2;

    typedef enum logic [4:0] {
        S_IDLE   = 5'b00001,
        S_LAUNCH = 5'b00010,
        S_WAIT   = 5'b00100,
        S_NEXT   = 5'b01000,
        S_DONE   = 5'b10000
    } sched_state_e;

    // Programmable job description written through the cfg port
    typedef struct packed {
        logic [DATA_W-1:0] in_base;
        logic [DATA_W-1:0] wt_base;
        logic [DATA_W-1:0] out_base;
        logic [DATA_W-1:0] fm_stride;
        logic [DATA_W-1:0] wt_stride;
    } job_cfg_t;

    // status_word layout, LSB is busy
    typedef struct packed {
        logic [19:0] rsvd;
        logic [3:0]  layers_done;
        logic [3:0]  layer_idx;
        logic        aborted;
        logic        timeout_err;
        logic        irq;
        logic        busy;
    } status_t;

endpackage

// File: rtl/sched_watchdog.sv
// Per-layer watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the count reaches TIMEOUT_CYC-1.
module sched_watchdog
    import accel_sched_pkg::*;
#(
    parameter logic [WD_W-1:0] TIMEOUT_CYC = 24'd1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    logic [WD_W-1:0] cnt;

    // expire is registered so that it is high while cnt == TIMEOUT_CYC-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            expire <= 1'b0;
        end else if (clear) begin
            cnt    <= '0;
            expire <= 1'b0;
        end else if (enable) begin
            cnt    <= cnt + WD_W'(1);
            expire <= ((cnt + WD_W'(1)) == (TIMEOUT_CYC - WD_W'(1)));
        end else begin
            expire <= 1'b0;
        end
    end

endmodule

// File: rtl/accel_layer_sched.sv
// Layer scheduler: sequences a multi-layer job on the compute core, stepping
// feature/weight addresses per layer, with watchdog, abort and sticky irq.
module accel_layer_sched
    import accel_sched_pkg::*;
#(
    parameter logic [WD_W-1:0] TIMEOUT_CYC = 24'd1000000,
    parameter int unsigned     LAYER_W     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  cfg_addr,
    input  logic [DATA_W-1:0]  cfg_data,
    input  logic               cfg_valid,
    output logic               core_start,
    output logic [DATA_W-1:0]  core_in_addr,
    output logic [DATA_W-1:0]  core_wt_addr,
    output logic [DATA_W-1:0]  core_out_addr,
    output logic [LAYER_W-1:0] core_layer_idx,
    input  logic               core_done,
    output logic               busy,
    output logic               irq,
    output logic [DATA_W-1:0]  status_word
);

    sched_state_e       state;
    job_cfg_t           prog_cfg;
    logic [LAYER_W-1:0] prog_cnt;
    logic [DATA_W-1:0]  sh_fm_stride;
    logic [DATA_W-1:0]  sh_wt_stride;
    logic [LAYER_W-1:0] sh_cnt;
    logic [LAYER_W-1:0] layers_done;
    logic [LAYER_W-1:0] done_inc;
    logic               timeout_err;
    logic               aborted;
    logic               ctrl_wr;
    logic               start_wr;
    logic               abort_wr;
    logic               clr_wr;
    logic               wd_expire;
    status_t            status_nxt;

    assign ctrl_wr  = cfg_valid && (cfg_addr == ADDR_CTRL);
    assign start_wr = ctrl_wr && cfg_data[CTRL_START];
    assign abort_wr = ctrl_wr && cfg_data[CTRL_ABORT];
    assign clr_wr   = ctrl_wr && cfg_data[CTRL_IRQ_CLR];
    assign done_inc = layers_done + LAYER_W'(1);

    // Programmable registers; only copied into the job on an accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prog_cfg <= '0;
            prog_cnt <= '0;
        end else if (cfg_valid) begin
            case (cfg_addr)
                ADDR_IN_BASE:   prog_cfg.in_base   <= cfg_data;
                ADDR_WT_BASE:   prog_cfg.wt_base   <= cfg_data;
                ADDR_OUT_BASE:  prog_cfg.out_base  <= cfg_data;
                ADDR_LAYER_CNT: prog_cnt           <= cfg_data[LAYER_W-1:0];
                ADDR_FM_STRIDE: prog_cfg.fm_stride <= cfg_data;
                ADDR_WT_STRIDE: prog_cfg.wt_stride <= cfg_data;
                default: ;
            endcase
        end
    end

    sched_watchdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state == S_LAUNCH),
        .enable (state == S_WAIT),
        .expire (wd_expire)
    );

    // Job FSM; irq_clear is applied first so a same-cycle set takes priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_IDLE;
            core_start     <= 1'b0;
            busy           <= 1'b0;
            irq            <= 1'b0;
            timeout_err    <= 1'b0;
            aborted        <= 1'b0;
            core_in_addr   <= '0;
            core_wt_addr   <= '0;
            core_out_addr  <= '0;
            core_layer_idx <= '0;
            layers_done    <= '0;
            sh_fm_stride   <= '0;
            sh_wt_stride   <= '0;
            sh_cnt         <= '0;
        end else begin
            core_start <= 1'b0;
            if (clr_wr) begin
                irq         <= 1'b0;
                timeout_err <= 1'b0;
                aborted     <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (start_wr) begin
                        core_in_addr   <= prog_cfg.in_base;
                        core_wt_addr   <= prog_cfg.wt_base;
                        core_out_addr  <= prog_cfg.out_base;
                        sh_fm_stride   <= prog_cfg.fm_stride;
                        sh_wt_stride   <= prog_cfg.wt_stride;
                        sh_cnt         <= prog_cnt;
                        core_layer_idx <= '0;
                        layers_done    <= '0;
                        if (prog_cnt != '0) begin
                            core_start <= 1'b1;
                            busy       <= 1'b1;
                            state      <= S_LAUNCH;
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                S_LAUNCH: begin
                    if (abort_wr) begin
                        aborted <= 1'b1;
                        busy    <= 1'b0;
                        state   <= S_DONE;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (abort_wr) begin
                        aborted <= 1'b1;
                        busy    <= 1'b0;
                        state   <= S_DONE;
                    end else if (core_done) begin
                        state <= S_NEXT;
                    end else if (wd_expire) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= S_DONE;
                    end
                end
                S_NEXT: begin
                    if (abort_wr) begin
                        aborted <= 1'b1;
                        busy    <= 1'b0;
                        state   <= S_DONE;
                    end else begin
                        layers_done <= done_inc;
                        if (done_inc == sh_cnt) begin
                            busy  <= 1'b0;
                            state <= S_DONE;
                        end else begin
                            core_in_addr   <= core_in_addr + sh_fm_stride;
                            core_out_addr  <= core_out_addr + sh_fm_stride;
                            core_wt_addr   <= core_wt_addr + sh_wt_stride;
                            core_layer_idx <= core_layer_idx + LAYER_W'(1);
                            core_start     <= 1'b1;
                            state          <= S_LAUNCH;
                        end
                    end
                end
                S_DONE: begin
                    irq   <= 1'b1;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        status_nxt             = '0;
        status_nxt.busy        = busy;
        status_nxt.irq         = irq;
        status_nxt.timeout_err = timeout_err;
        status_nxt.aborted     = aborted;
        status_nxt.layer_idx   = 4'(core_layer_idx);
        status_nxt.layers_done = 4'(layers_done);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_word <= '0;
        end else begin
            status_word <= status_nxt;
        end
    end

endmodule

// File: tb/tb_accel_layer_sched.sv
// Scoreboard bench for accel_layer_sched: expected launches are queued at job
// start and checked by a monitor on every core_start pulse.
module tb_accel_layer_sched;

    localparam int TO = 16;
    localparam logic [5:0] A_IN   = 6'd21;
    localparam logic [5:0] A_WT   = 6'd22;
    localparam logic [5:0] A_OUT  = 6'd23;
    localparam logic [5:0] A_CNT  = 6'd24;
    localparam logic [5:0] A_FS   = 6'd25;
    localparam logic [5:0] A_WS   = 6'd26;
    localparam logic [5:0] A_CTRL = 6'd27;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  cfg_addr = '0;
    logic [31:0] cfg_data = '0;
    logic        cfg_valid = 1'b0;
    logic        core_start;
    logic [31:0] core_in_addr, core_wt_addr, core_out_addr;
    logic [3:0]  core_layer_idx;
    logic        core_done = 1'b0;
    logic        busy, irq;
    logic [31:0] status_word;

    typedef struct {
        logic [31:0] in_a;
        logic [31:0] wt_a;
        logic [31:0] out_a;
        int          idx;
    } launch_t;

    launch_t exp_q[$];
    int checks = 0;
    int failures = 0;

    accel_layer_sched #(
        .TIMEOUT_CYC (24'd16),
        .LAYER_W     (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_addr       (cfg_addr),
        .cfg_data       (cfg_data),
        .cfg_valid      (cfg_valid),
        .core_start     (core_start),
        .core_in_addr   (core_in_addr),
        .core_wt_addr   (core_wt_addr),
        .core_out_addr  (core_out_addr),
        .core_layer_idx (core_layer_idx),
        .core_done      (core_done),
        .busy           (busy),
        .irq            (irq),
        .status_word    (status_word)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every launch pulse must match the oldest expected launch
    always @(negedge clk) begin
        launch_t e;
        if (rst_n && core_start) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_core_start", 32'(core_start), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("launch_in_addr", core_in_addr, e.in_a);
                chk("launch_wt_addr", core_wt_addr, e.wt_a);
                chk("launch_out_addr", core_out_addr, e.out_a);
                chk("launch_layer_idx", 32'(core_layer_idx), 32'(e.idx));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_wr(input logic [5:0] a, input logic [31:0] d);
        cfg_addr  = a;
        cfg_data  = d;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        cfg_data  = $urandom;
    endtask

    task automatic pulse_done();
        core_done = 1'b1;
        step();
        core_done = 1'b0;
    endtask

    task automatic wait_start();
        for (int n = 0; n < 40 && !core_start; n++) @(negedge clk);
        chk("wait_core_start", 32'(core_start), 32'd1);
    endtask

    task automatic wait_irq();
        for (int n = 0; n < 80 && !irq; n++) @(negedge clk);
        chk("wait_irq", 32'(irq), 32'd1);
    endtask

    // mode: 0 normal, 1 abort at layer k, 2 timeout at layer k,
    //       3 abort coincident with core_done at layer k,
    //       4 normal with IN_BASE rewrite and start write during layer k
    task automatic run_job(input logic [31:0] in_b, input logic [31:0] wt_b,
                           input logic [31:0] out_b, input logic [31:0] fs,
                           input logic [31:0] ws, input int cnt, input int mode,
                           input int k, input int dly, input bit wr_in);
        int          n_launch;
        int          exp_done;
        int          busy_cyc;
        int          d;
        launch_t     l;
        logic [31:0] exp_st;
        if (wr_in) cfg_wr(A_IN, in_b);
        cfg_wr(A_WT, wt_b);
        cfg_wr(A_OUT, out_b);
        cfg_wr(A_FS, fs);
        cfg_wr(A_WS, ws);
        cfg_wr(A_CNT, ($urandom << 4) | 32'(cnt));
        cfg_wr(6'd28 + 6'($urandom_range(0, 1)), $urandom);
        n_launch = (mode == 0 || mode == 4) ? cnt : k + 1;
        exp_done = (mode == 0 || mode == 4) ? cnt : k;
        for (int i = 0; i < n_launch; i++) begin
            l.in_a  = in_b + 32'(i) * fs;
            l.out_a = out_b + 32'(i) * fs;
            l.wt_a  = wt_b + 32'(i) * ws;
            l.idx   = i;
            exp_q.push_back(l);
        end
        cfg_wr(A_CTRL, 32'h5);
        chk("irq_cleared_by_start", 32'(irq), 32'd0);
        for (int i = 0; i < n_launch; i++) begin
            wait_start();
            if (i == k && mode == 1) begin
                step();
                step();
                cfg_wr(A_CTRL, 32'h2);
            end else if (i == k && mode == 3) begin
                step();
                step();
                cfg_addr  = A_CTRL;
                cfg_data  = 32'h2;
                cfg_valid = 1'b1;
                core_done = 1'b1;
                step();
                cfg_valid = 1'b0;
                core_done = 1'b0;
            end else if (i == k && mode == 2) begin
                step();
                busy_cyc = 0;
                for (int n = 0; n < 60 && busy; n++) begin
                    busy_cyc++;
                    step();
                end
                chk("timeout_wait_cycles", 32'(busy_cyc), 32'(TO));
            end else begin
                step();
                if (i == k && mode == 4) begin
                    cfg_wr(A_IN, in_b ^ 32'h00F0_0000);
                    cfg_wr(A_CTRL, 32'h1);
                end
                d = (dly < 0) ? $urandom_range(0, 5) : dly;
                repeat (d) step();
                pulse_done();
            end
        end
        wait_irq();
        @(negedge clk);
        exp_st = (32'(exp_done) << 8) | (32'(n_launch - 1) << 4) | 32'h2;
        if (mode == 1 || mode == 3) exp_st = exp_st | 32'h8;
        if (mode == 2) exp_st = exp_st | 32'h4;
        chk("status_word", status_word, exp_st);
        chk("busy_after_job", 32'(busy), 32'd0);
        chk("launches_outstanding", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        int          cnt, mode, k;
        launch_t     l;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_core_start", 32'(core_start), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_irq", 32'(irq), 32'd0);
        chk("reset_status", status_word, 32'd0);
        chk("reset_in_addr", core_in_addr, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("post_reset_irq", 32'(irq), 32'd0);
        chk("post_reset_busy", 32'(busy), 32'd0);

        // Three-layer job, done ten cycles after each launch
        run_job(32'h1000, 32'h8000, 32'h0002_0000, 32'h100, 32'h40, 3, 0, 0, 10, 1'b1);

        // Zero-layer job: no launch, irq two cycles after the start write
        cfg_wr(A_CNT, 32'h0);
        cfg_wr(A_CTRL, 32'h5);
        chk("zero_cnt_busy0", 32'(busy), 32'd0);
        chk("zero_cnt_irq_early", 32'(irq), 32'd0);
        step();
        chk("zero_cnt_irq", 32'(irq), 32'd1);
        chk("zero_cnt_busy1", 32'(busy), 32'd0);
        step();
        chk("zero_cnt_status", status_word, 32'h2);

        // Timeout on first of two layers
        run_job($urandom, $urandom, $urandom, $urandom, $urandom, 2, 2, 0, -1, 1'b1);
        // Abort coincident with core_done in the first of four layers
        run_job($urandom, $urandom, $urandom, $urandom, $urandom, 4, 3, 0, -1, 1'b1);
        // Mid-job start + IN_BASE rewrite ignored; next job picks up new base
        run_job(32'h1000, 32'h8000, 32'h4000, 32'h100, 32'h40, 3, 4, 0, -1, 1'b1);
        run_job(32'h00F0_1000, 32'h8000, 32'h4000, 32'h100, 32'h40, 2, 0, 0, -1, 1'b0);
        // Maximum layer count with address wrap-around
        run_job(32'hFFFF_FF00, 32'hFFFF_FFF0, 32'hFFFF_0000, 32'h80, 32'h8, 15, 0, 0, 0, 1'b1);

        for (int j = 0; j < 8; j++) begin
            cnt  = $urandom_range(1, 15);
            mode = $urandom_range(0, 4);
            k    = $urandom_range(0, cnt - 1);
            run_job($urandom, $urandom, $urandom, $urandom, $urandom, cnt, mode, k, -1, 1'b1);
        end

        // Reset during WAIT, then a stray core_done must do nothing
        cfg_wr(A_IN, 32'hA000);
        cfg_wr(A_WT, 32'hB000);
        cfg_wr(A_OUT, 32'hC000);
        cfg_wr(A_CNT, 32'h2);
        l.in_a  = 32'hA000;
        l.wt_a  = 32'hB000;
        l.out_a = 32'hC000;
        l.idx   = 0;
        exp_q.push_back(l);
        cfg_wr(A_CTRL, 32'h5);
        wait_start();
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("rst_core_start", 32'(core_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_status", status_word, 32'd0);
        chk("rst_in_addr", core_in_addr, 32'd0);
        chk("rst_wt_addr", core_wt_addr, 32'd0);
        chk("rst_out_addr", core_out_addr, 32'd0);
        chk("rst_layer_idx", 32'(core_layer_idx), 32'd0);
        chk("rst_queue_drained", 32'(exp_q.size()), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        pulse_done();
        repeat (3) step();
        chk("stray_done_busy", 32'(busy), 32'd0);
        chk("stray_done_irq", 32'(irq), 32'd0);
        chk("stray_done_status", status_word, 32'd0);
        // Layer count was reset to zero, so a bare start finishes immediately
        cfg_wr(A_CTRL, 32'h1);
        step();
        chk("post_rst_start_irq", 32'(irq), 32'd1);
        chk("post_rst_start_busy", 32'(busy), 32'd0);
        repeat (3) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/accel_layer_sched.md
ACCEL_LAYER_SCHED -- requirements
Module: accel_layer_sched

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 24'd1000000, meaning watchdog cycles allowed per layer in WAIT.
REQ-002 SHALL have parameter LAYER_W, default 4, meaning width of the layer count and layer index fields.
REQ-003 Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cfg_addr  in  6  register address
- cfg_data  in  32  register write data
- cfg_valid  in  1  one-cycle write strobe
- core_start  out  1  one-cycle layer launch pulse
- core_in_addr  out  32  input feature base, current layer
- core_wt_addr  out  32  weight base, current layer
- core_out_addr  out  32  output feature base, current layer
- core_layer_idx  out  LAYER_W  current layer index
- core_done  in  1  one-cycle layer-complete pulse from core
- busy  out  1  job in progress
- irq  out  1  sticky job-finished interrupt
- status_word  out  32  readable status

Function
REQ-004 Register map on cfg_valid: 21 IN_BASE, 22 WT_BASE, 23 OUT_BASE, 24 LAYER_CNT (low LAYER_W bits), 25 FM_STRIDE, 26 WT_STRIDE, 27 CTRL (bit0 start, bit1 abort, bit2 irq_clear); writes to 28-29 and all other addresses SHALL be ignored.
REQ-005 States SHALL be IDLE, LAUNCH, WAIT, NEXT, DONE; one-hot encoding.
REQ-006 IDLE -> LAUNCH on start write with LAYER_CNT != 0; IDLE -> DONE on start write with LAYER_CNT == 0 (no core_start issued).
REQ-007 On accepted start, base, stride and count registers SHALL be copied into shadow registers; later cfg writes update only the programmable registers, never the running job.
REQ-008 Start writes while busy SHALL be ignored.
REQ-009 core_start SHALL be high exactly in LAUNCH (one cycle); LAUNCH -> WAIT unconditionally.
REQ-010 Start write sampled at edge k -> core_start high in cycle k..k+1, i.e. latency 1 cycle.
REQ-011 WAIT -> NEXT on core_done; core_done outside WAIT SHALL be ignored.
REQ-012 NEXT: layers_done += 1; if layers_done == shadow count -> DONE, else in/out addr += FM_STRIDE, wt addr += WT_STRIDE (mod 2^32), layer_idx += 1, -> LAUNCH.
REQ-013 Watchdog SHALL clear on WAIT entry; reaching TIMEOUT_CYC-1 in WAIT without core_done sets sticky timeout_err -> DONE.
REQ-014 Abort write in LAUNCH/WAIT/NEXT SHALL set sticky aborted -> DONE; abort and core_done in the same cycle: abort wins; abort in IDLE ignored.
REQ-015 DONE (one cycle): irq <= 1 -> IDLE.
REQ-016 irq_clear SHALL clear irq, timeout_err, aborted; irq_clear+start in one write: clear first, then start; DONE setting irq in the same cycle as irq_clear: set wins.
REQ-017 busy SHALL be high in LAUNCH, WAIT, NEXT.
REQ-018 status_word: [0] busy, [1] irq, [2] timeout_err, [3] aborted, [7:4] layer_idx, [11:8] layers_done, others 0; registered, 1-cycle latency.

Reset
REQ-019 On rst_n low, all outputs, programmable and shadow registers, counters and flags SHALL be 0 and state IDLE, including mid-job.
REQ-020 Reset deassertion SHALL not generate core_start or irq.

Structure
REQ-021 Package accel_sched_pkg SHALL hold register address constants, CTRL bit positions, state encodings, status_word bit positions.
REQ-022 Watchdog SHALL be sub-module sched_watchdog (clear, enable, expire); all else in the top.

Verification
REQ-023 LAYER_CNT=3, IN=0x1000, FM_STRIDE=0x100, WT=0x8000, WT_STRIDE=0x40, start, done 10 cycles after each start -> 3 core_start pulses, in_addr 0x1000/0x1100/0x1200, wt 0x8000/0x8040/0x8080, irq=1, status[11:8]=3.
REQ-024 LAYER_CNT=0, start -> no core_start, irq=1 two cycles later, busy never high.
REQ-025 TIMEOUT_CYC=16, LAYER_CNT=2, no core_done -> DONE after 16 WAIT cycles, status[2]=1, one core_start only.
REQ-026 Abort coincident with core_done in layer 1 of 4 -> status[3]=1, layers_done=0, no further core_start.
REQ-027 Start mid-job plus IN_BASE rewrite -> ignored; running addresses unchanged; next job uses new IN_BASE.
REQ-028 rst_n low during WAIT -> all outputs 0 immediately; after release, a core_done pulse -> no state change.
